// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DRAIN,
        S_HALT
    } fetch_state_t;

    localparam logic [5:0]  OP_STOP          = 6'b111111;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Force an address onto a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/fetch_ir.sv
// Instruction register toward decode: instruction word, its PC, PC+4 and a
// valid flag. Flush beats load, load beats consume.
module fetch_ir
    import fetch_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_flush,
    input  logic        i_load,
    input  logic [31:0] i_data,
    input  logic [31:0] i_pc,
    input  logic        i_consume,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic [31:0] o_pcplus4
);

    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic [31:0] r_pcplus4;

    // IR update: a refill in the same cycle as a consume keeps the IR full.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid   <= 1'b0;
            r_instr   <= '0;
            r_pc      <= '0;
            r_pcplus4 <= '0;
        end else if (i_flush) begin
            r_valid   <= 1'b0;
        end else if (i_load) begin
            r_valid   <= 1'b1;
            r_instr   <= i_data;
            r_pc      <= i_pc;
            r_pcplus4 <= i_pc + PC_STEP;
        end else if (i_consume && r_valid) begin
            r_valid   <= 1'b0;
        end
    end

    assign o_valid   = r_valid;
    assign o_instr   = r_instr;
    assign o_pc      = r_pc;
    assign o_pcplus4 = r_pcplus4;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, memory request FSM, redirect squashing and a
// one-entry IR toward decode.
// Optional feature macro: FETCH_STOP_EN (freeze fetch after a stop opcode).
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pcplus4,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        halted
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic         w_ir_valid;
    logic         w_redirect;
    logic         w_req;
    logic         w_fire;
    logic         w_capture;
    logic         w_is_stop;

    // Redirects are ignored once fetch is frozen.
    assign w_redirect = redirect && (r_state != S_HALT);

    // Request only when the IR is free or draining this cycle; reset_n gating
    // keeps the request low while reset is held.
    assign w_req     = reset_n && (r_state == S_REQ) && !w_redirect &&
                       (!w_ir_valid || instr_ready);
    assign w_fire    = w_req && imem_ack;
    assign w_capture = (r_state == S_WAIT) && imem_rvalid && !w_redirect;

`ifdef FETCH_STOP_EN
    logic r_halted;
    assign w_is_stop = (imem_rdata[31:26] == OP_STOP);
    assign halted    = r_halted;
`else
    assign w_is_stop = 1'b0;
    assign halted    = 1'b0;
`endif

    // FSM and PC register; redirect takes priority over every other event.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_REQ;
            r_pc     <= RESET_PC;
`ifdef FETCH_STOP_EN
            r_halted <= 1'b0;
`endif
        end else begin
            if (w_redirect) begin
                r_pc <= align_word(redirect_pc);
            end else if (w_capture) begin
                r_pc <= r_pc + PC_STEP;
            end

            case (r_state)
                // The request is suppressed during a redirect, so an accepted
                // request here is never wrong-path.
                S_REQ: begin
                    if (w_fire) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        r_state <= (w_capture && w_is_stop) ? S_HALT : S_REQ;
                    end else if (w_redirect) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (imem_rvalid) begin
                        r_state <= S_REQ;
                    end
                end
                S_HALT: begin
`ifdef FETCH_STOP_EN
                    if (w_ir_valid && instr_ready) begin
                        r_halted <= 1'b1;
                    end
`endif
                end
                default: r_state <= S_REQ;
            endcase
        end
    end

    fetch_ir u_ir (
        .i_clk     (clk),
        .i_rst_n   (reset_n),
        .i_flush   (w_redirect),
        .i_load    (w_capture),
        .i_data    (imem_rdata),
        .i_pc      (r_pc),
        .i_consume (instr_ready),
        .o_valid   (w_ir_valid),
        .o_instr   (instr),
        .o_pc      (instr_pc),
        .o_pcplus4 (instr_pcplus4)
    );

    assign imem_req    = w_req;
    assign imem_addr   = r_pc;
    assign instr_valid = w_ir_valid;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a small instruction memory model.
module tb_instr_fetch;

    logic        clk;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pcplus4;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halted;

    int n_cmp = 0;
    int n_err = 0;

    // memory model state
    int          lat = 1;
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [31:0] paddr = '0;

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_pcplus4 (instr_pcplus4),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .halted        (halted)
    );

    // memory always accepts a request in the cycle it is made
    assign imem_ack = imem_req;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h2008_0005;
            32'h0000_0004: return 32'h8C09_0004;
            32'h0000_0008: return 32'hDEAD_BEEF;
            32'h0000_0200: return 32'hFC00_0000;
            32'hFFFF_FFFC: return 32'h2401_FFFF;
            default:       return {8'h01, a[23:0]};
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; memory answers an accepted request 'lat' cycles later.
    task automatic tick();
        logic        fire;
        logic [31:0] a;
        #1;
        fire = imem_req && imem_ack;
        a    = imem_addr;
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        redirect    = 1'b0;
        if (!reset_n) begin
            pend = 1'b0;
        end else begin
            if (fire) begin
                pend  = 1'b1;
                cnt   = lat;
                paddr = a;
            end
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(paddr);
                    pend        = 1'b0;
                end
            end
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n     = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_req",    {31'd0, imem_req},    32'd0);
        check_eq("rst_valid",  {31'd0, instr_valid}, 32'd0);
        check_eq("rst_instr",  instr,                32'd0);
        check_eq("rst_pc",     instr_pc,             32'd0);
        check_eq("rst_pc4",    instr_pcplus4,        32'd0);
        check_eq("rst_halted", {31'd0, halted},      32'd0);

        // 1: first fetch, 1-cycle memory
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_eq("t1_req0",  {31'd0, imem_req}, 32'd1);
        check_eq("t1_addr0", imem_addr,         32'h0);
        tick();
        check_eq("t1_wait_req",   {31'd0, imem_req},    32'd0);
        check_eq("t1_wait_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        check_eq("t1_valid", {31'd0, instr_valid}, 32'd1);
        check_eq("t1_instr", instr,                32'h2008_0005);
        check_eq("t1_ipc",   instr_pc,             32'h0);
        check_eq("t1_pc4",   instr_pcplus4,        32'h4);
        check_eq("t1_addr4", imem_addr,            32'h4);

        // 2: decode stalls with IR full
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("t2_stall_req",   {31'd0, imem_req}, 32'd0);
            check_eq("t2_stall_instr", instr,             32'h2008_0005);
        end
        instr_ready = 1'b1;
        #1;
        check_eq("t2_req_on_ready", {31'd0, imem_req}, 32'd1);
        check_eq("t2_addr",         imem_addr,         32'h4);
        tick();
        check_eq("t2_drained", {31'd0, instr_valid}, 32'd0);
        tick();
        check_eq("t2_valid", {31'd0, instr_valid}, 32'd1);
        check_eq("t2_instr", instr,                32'h8C09_0004);
        check_eq("t2_ipc",   instr_pc,             32'h4);
        check_eq("t2_req",   {31'd0, imem_req},    32'd1);
        check_eq("t2_addr8", imem_addr,            32'h8);

        // 3: redirect while waiting, late response dropped
        lat = 2;
        tick();
        check_eq("t3_wait_req", {31'd0, imem_req}, 32'd0);
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        tick();
        check_eq("t3_drain_req", {31'd0, imem_req},    32'd0);
        check_eq("t3_rvalid_tb", {31'd0, imem_rvalid}, 32'd1);
        tick();
        check_eq("t3_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("t3_instr", instr,                32'h8C09_0004);
        check_eq("t3_req",   {31'd0, imem_req},    32'd1);
        check_eq("t3_addr",  imem_addr,            32'h40);

        // 4: redirect with rvalid in the same cycle, then PC wrap
        lat = 1;
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h103;
        tick();
        check_eq("t4_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("t4_req",   {31'd0, imem_req},    32'd1);
        check_eq("t4_addr",  imem_addr,            32'h100);
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        #1;
        check_eq("t4_req_off_redirect", {31'd0, imem_req}, 32'd0);
        tick();
        check_eq("t4_wrap_req",  {31'd0, imem_req}, 32'd1);
        check_eq("t4_wrap_addr", imem_addr,         32'hFFFF_FFFC);
        tick();
        tick();
        check_eq("t4_wrap_valid", {31'd0, instr_valid}, 32'd1);
        check_eq("t4_wrap_instr", instr,                32'h2401_FFFF);
        check_eq("t4_wrap_ipc",   instr_pc,             32'hFFFF_FFFC);
        check_eq("t4_wrap_pc4",   instr_pcplus4,        32'h0);
        check_eq("t4_wrap_next",  imem_addr,            32'h0);
        check_eq("t4_halted",     {31'd0, halted},      32'd0);

`ifdef FETCH_STOP_EN
        // 5: stop opcode freezes fetch
        begin
            int req_seen;
            redirect    = 1'b1;
            redirect_pc = 32'h200;
            tick();
            check_eq("t5_flushed", {31'd0, instr_valid}, 32'd0);
            tick();
            tick();
            check_eq("t5_valid",    {31'd0, instr_valid}, 32'd1);
            check_eq("t5_instr",    instr,                32'hFC00_0000);
            check_eq("t5_pre_halt", {31'd0, halted},      32'd0);
            check_eq("t5_req",      {31'd0, imem_req},    32'd0);
            instr_ready = 1'b0;
            tick();
            check_eq("t5_hold_halt", {31'd0, halted},      32'd0);
            check_eq("t5_hold_val",  {31'd0, instr_valid}, 32'd1);
            instr_ready = 1'b1;
            tick();
            check_eq("t5_halted",  {31'd0, halted},      32'd1);
            check_eq("t5_consumed", {31'd0, instr_valid}, 32'd0);
            req_seen = 0;
            for (int i = 0; i < 20; i++) begin
                redirect    = 1'b1;
                redirect_pc = 32'h0;
                #1;
                if (imem_req) req_seen++;
                tick();
            end
            check_eq("t5_no_req",    req_seen,          32'd0);
            check_eq("t5_still_hlt", {31'd0, halted},   32'd1);
            reset_n = 1'b0;
            #1;
            check_eq("t5_rst_halted", {31'd0, halted},   32'd0);
            check_eq("t5_rst_req",    {31'd0, imem_req}, 32'd0);
            @(negedge clk);
            reset_n = 1'b1;
            #1;
            check_eq("t5_restart_req",  {31'd0, imem_req}, 32'd1);
            check_eq("t5_restart_addr", imem_addr,         32'h0);
            tick();
            tick();
        end
`endif

        // reset mid-operation clears everything
        tick();
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("mid_rst_instr", instr,                32'd0);
        check_eq("mid_rst_req",   {31'd0, imem_req},    32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_eq("mid_rst_addr", imem_addr, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
